// File: rtl/lmu_meas_ctrl.sv
// Sequencing controller for LMU measurement interpretation: latches one logical-measurement
// record, evaluates its interpreted outcome, and owns sign/byproduct/magic-state "a" state.

`ifndef PP_I
`define PP_I 2'b00
`endif
`ifndef PP_X
`define PP_X 2'b01
`endif
`ifndef PP_Z
`define PP_Z 2'b10
`endif
`ifndef PP_Y
`define PP_Y 2'b11
`endif
`ifndef FBXORZ_INVALID
`define FBXORZ_INVALID 2'b00
`endif
`ifndef FBXORZ_X
`define FBXORZ_X 2'b01
`endif
`ifndef FBXORZ_Z
`define FBXORZ_Z 2'b10
`endif
`ifndef MEASSIGN_PLUS
`define MEASSIGN_PLUS 1'b0
`endif

module lmu_meas_ctrl #(
  parameter int unsigned NUM_LQ = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  meas_valid,
  output logic                  meas_ready,
  input  logic [NUM_LQ*2-1:0]   lpplist,
  input  logic [NUM_LQ*2-1:0]   byproduct,
  input  logic                  meas_sign,
  input  logic                  init_meas,
  input  logic                  byproduct_check,
  input  logic                  meas_is_a,
  input  logic                  sign_upd_valid,
  input  logic [NUM_LQ-1:0]     sign_upd_x,
  input  logic [NUM_LQ-1:0]     sign_upd_z,
  input  logic                  lq_clear,
  input  logic                  a_valid,
  input  logic                  a_val,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  final_meas,
  output logic [NUM_LQ*2-1:0]   byproduct_acc,
  output logic [1:0]            measfb_xorz,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StEval, StOut} state_e;

  state_e                state_q;
  logic [NUM_LQ*2-1:0]   lpp_q;
  logic [NUM_LQ*2-1:0]   bpp_q;
  logic                  sign_q;
  logic                  init_q;
  logic                  bchk_q;
  logic                  is_a_q;
  logic [NUM_LQ-1:0]     sign_x_acc;
  logic [NUM_LQ-1:0]     sign_z_acc;
  logic                  a_sign;
  logic                  a_taken;

  logic                  not_commute;
  logic                  lqsign;
  logic                  meas_calc;
  logic                  fb_fire;

  always_comb begin
    not_commute = 1'b0;
    lqsign      = 1'b0;
    for (int i = 0; i < int'(NUM_LQ); i++) begin
      logic [1:0] lp;
      logic [1:0] bp;
      lp = lpp_q[i*2 +: 2];
      bp = bpp_q[i*2 +: 2];
      not_commute ^= (lp != bp) && (lp != `PP_I) && (bp != `PP_I);
      unique case (lp)
        `PP_X:   lqsign ^= sign_x_acc[i];
        `PP_Z:   lqsign ^= sign_z_acc[i];
        `PP_Y:   lqsign ^= sign_x_acc[i] ^ sign_z_acc[i];
        default: ;
      endcase
    end
    meas_calc = (not_commute & bchk_q) ^ lqsign ^ sign_q ^ init_q;
  end

  // Gated by rst so the code reads INVALID while reset is held.
  assign fb_fire     = a_valid & ~a_taken & ~rst;
  assign measfb_xorz = !fb_fire         ? `FBXORZ_INVALID :
                       (a_val ^ a_sign) ? `FBXORZ_X : `FBXORZ_Z;
  assign meas_ready  = (state_q == StIdle);
  assign busy        = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      lpp_q         <= '0;
      bpp_q         <= '0;
      sign_q        <= 1'b0;
      init_q        <= 1'b0;
      bchk_q        <= 1'b0;
      is_a_q        <= 1'b0;
      sign_x_acc    <= '0;
      sign_z_acc    <= '0;
      byproduct_acc <= '0;
      a_sign        <= `MEASSIGN_PLUS;
      a_taken       <= 1'b0;
      final_meas    <= 1'b0;
      out_valid     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (meas_valid) begin
            lpp_q   <= lpplist;
            bpp_q   <= byproduct;
            sign_q  <= meas_sign;
            init_q  <= init_meas;
            bchk_q  <= byproduct_check;
            is_a_q  <= meas_is_a;
            state_q <= StEval;
          end
        end
        StEval: begin
          final_meas <= meas_calc;
          out_valid  <= 1'b1;
          state_q    <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (lq_clear) begin
        sign_x_acc    <= '0;
        sign_z_acc    <= '0;
        byproduct_acc <= '0;
      end else begin
        if (sign_upd_valid) begin
          sign_x_acc <= sign_x_acc ^ sign_upd_x;
          sign_z_acc <= sign_z_acc ^ sign_upd_z;
        end
        if (state_q == StEval) byproduct_acc <= byproduct_acc ^ bpp_q;
      end

      // A fresh capture re-arms feedback even if the old value fires this same cycle.
      if (lq_clear) begin
        a_sign  <= `MEASSIGN_PLUS;
        a_taken <= 1'b1;
      end else if (state_q == StEval && is_a_q) begin
        a_sign  <= meas_calc;
        a_taken <= 1'b0;
      end else if (fb_fire) begin
        a_taken <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lmu_meas_ctrl.sv
// Directed-vector bench for lmu_meas_ctrl with hand-computed expected values.

module tb_lmu_meas_ctrl;

  localparam logic [1:0] FbInvalid = 2'b00;
  localparam logic [1:0] FbX       = 2'b01;
  localparam logic [1:0] FbZ       = 2'b10;

  logic       clk = 1'b0;
  logic       rst;
  logic       meas_valid;
  logic       meas_ready;
  logic [3:0] lpplist;
  logic [3:0] byproduct;
  logic       meas_sign;
  logic       init_meas;
  logic       byproduct_check;
  logic       meas_is_a;
  logic       sign_upd_valid;
  logic [1:0] sign_upd_x;
  logic [1:0] sign_upd_z;
  logic       lq_clear;
  logic       a_valid;
  logic       a_val;
  logic       out_valid;
  logic       out_ready;
  logic       final_meas;
  logic [3:0] byproduct_acc;
  logic [1:0] measfb_xorz;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  logic fm;

  lmu_meas_ctrl #(.NUM_LQ(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .meas_valid      (meas_valid),
    .meas_ready      (meas_ready),
    .lpplist         (lpplist),
    .byproduct       (byproduct),
    .meas_sign       (meas_sign),
    .init_meas       (init_meas),
    .byproduct_check (byproduct_check),
    .meas_is_a       (meas_is_a),
    .sign_upd_valid  (sign_upd_valid),
    .sign_upd_x      (sign_upd_x),
    .sign_upd_z      (sign_upd_z),
    .lq_clear        (lq_clear),
    .a_valid         (a_valid),
    .a_val           (a_val),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .final_meas      (final_meas),
    .byproduct_acc   (byproduct_acc),
    .measfb_xorz     (measfb_xorz),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rec(input logic [3:0] lpp, input logic [3:0] bpp, input logic ms,
                           input logic bc, input logic isa);
    lpplist         = lpp;
    byproduct       = bpp;
    meas_sign       = ms;
    init_meas       = 1'b0;
    byproduct_check = bc;
    meas_is_a       = isa;
    meas_valid      = 1'b1;
  endtask

  // Full transaction: accept, EVAL, OUT, then handshake back to IDLE.
  task automatic run_rec(input string tag, input logic [3:0] lpp, input logic [3:0] bpp,
                         input logic ms, input logic bc, input logic isa, output logic res);
    int t = 0;
    drive_rec(lpp, bpp, ms, bc, isa);
    while (!meas_ready && t < 20) begin
      step();
      t++;
    end
    check({tag, "_ready"}, meas_ready, 1);
    step();
    meas_valid = 1'b0;
    check({tag, "_eval_ov"}, out_valid, 0);
    step();
    check({tag, "_ov"}, out_valid, 1);
    res = final_meas;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; meas_valid = 1'b0; lpplist = '0; byproduct = '0; meas_sign = 1'b0;
    init_meas = 1'b0; byproduct_check = 1'b0; meas_is_a = 1'b0; sign_upd_valid = 1'b0;
    sign_upd_x = '0; sign_upd_z = '0; lq_clear = 1'b0; a_valid = 1'b0; a_val = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_ready", meas_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_ov", out_valid, 0);
    check("rst_bacc", byproduct_acc, 0);
    check("rst_fm", final_meas, 0);
    check("rst_fb", measfb_xorz, FbInvalid);

    // lpplist = X on q0, Z on q1; sign 1
    run_rec("basic", 4'b1001, 4'b0000, 1'b1, 1'b0, 1'b0, fm);
    check("basic_fm", fm, 1);
    check("basic_bacc", byproduct_acc, 0);

    // X sign flip on q0, measure Y on q0
    sign_upd_valid = 1'b1; sign_upd_x = 2'b01; step(); sign_upd_valid = 1'b0; sign_upd_x = '0;
    run_rec("y_x", 4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0, fm);
    check("y_x_fm", fm, 1);
    sign_upd_valid = 1'b1; sign_upd_z = 2'b01; step(); sign_upd_valid = 1'b0; sign_upd_z = '0;
    run_rec("y_xz", 4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0, fm);
    check("y_xz_fm", fm, 0);

    // Byproduct commutation
    lq_clear = 1'b1; step(); lq_clear = 1'b0;
    run_rec("bp_chk", 4'b0001, 4'b0010, 1'b0, 1'b1, 1'b0, fm);
    check("bp_chk_fm", fm, 1);
    check("bp_chk_bacc", byproduct_acc, 4'b0010);
    run_rec("bp_nochk", 4'b0001, 4'b0010, 1'b0, 1'b0, 1'b0, fm);
    check("bp_nochk_fm", fm, 0);
    check("bp_nochk_bacc", byproduct_acc, 0);

    // Magic-state "a" feedback
    run_rec("a1", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, fm);
    check("a1_fm", fm, 1);
    a_valid = 1'b1; a_val = 1'b0; #1;
    check("fb_x", measfb_xorz, FbX);
    step();
    check("fb_once1", measfb_xorz, FbInvalid);
    step();
    check("fb_once2", measfb_xorz, FbInvalid);
    step();
    a_valid = 1'b0;
    run_rec("a0", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, fm);
    check("a0_fm", fm, 0);
    a_valid = 1'b1; #1;
    check("fb_z", measfb_xorz, FbZ);
    step();
    a_valid = 1'b0;

    // Output stall
    drive_rec(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    step();
    meas_sign = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall_ov", out_valid, 1);
      check("stall_fm", final_meas, 1);
      check("stall_ready", meas_ready, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("stall_idle_ready", meas_ready, 1);
    check("stall_idle_busy", busy, 0);
    step();
    meas_valid = 1'b0;
    check("next_busy", busy, 1);
    step();
    check("next_ov", out_valid, 1);
    check("next_fm", final_meas, 0);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Reset in OUT with live accumulators
    sign_upd_valid = 1'b1; sign_upd_x = 2'b11; sign_upd_z = 2'b11; step();
    sign_upd_valid = 1'b0; sign_upd_x = '0; sign_upd_z = '0;
    drive_rec(4'b0000, 4'b0101, 1'b1, 1'b0, 1'b0);
    step();
    meas_valid = 1'b0;
    step();
    check("pre_rst_ov", out_valid, 1);
    check("pre_rst_bacc", byproduct_acc, 4'b0101);
    rst = 1'b1; step(); rst = 1'b0;
    check("mid_rst_ov", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_bacc", byproduct_acc, 0);
    check("mid_rst_fm", final_meas, 0);
    run_rec("post_rst", 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, fm);
    check("post_rst_fm", fm, 0);

    // lq_clear beats a coincident sign update
    sign_upd_valid = 1'b1; sign_upd_x = 2'b01; step();
    lq_clear = 1'b1; sign_upd_x = 2'b01; sign_upd_z = 2'b10; step();
    lq_clear = 1'b0; sign_upd_valid = 1'b0; sign_upd_x = '0; sign_upd_z = '0;
    run_rec("clr", 4'b1001, 4'b0000, 1'b0, 1'b0, 1'b0, fm);
    check("clr_fm", fm, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lmu_meas_ctrl.md
Name: lmu_meas_ctrl

Overview:
- Sequencing controller for the LMU measurement-interpretation datapath.
- Accepts one logical-measurement record at a time and owns the state that interpretation needs: accumulated logical-qubit sign registers, accumulated byproduct register, and the magic-state "a" sign and taken flags.
- Produces the final measurement outcome through a valid/ready output handshake.
- Issues one-shot X/Z feedback decisions when the magic-state "a" measurement arrives.

Parameters:
- NUM_LQ, 2, number of logical qubits; each Pauli vector is NUM_LQ*2 bits, 2 bits per qubit, qubit I at bits [I*2+:2].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- meas_valid  in  1  measurement record offered
- meas_ready  out  1  controller can accept a record
- lpplist  in  NUM_LQ*2  logical Pauli product measured
- byproduct  in  NUM_LQ*2  byproduct Pauli reported with this record
- meas_sign  in  1  raw physical parity result
- init_meas  in  1  initial-sign correction bit
- byproduct_check  in  1  apply byproduct commutation correction
- meas_is_a  in  1  record is the magic-state "a" sign measurement
- sign_upd_valid  in  1  apply logical sign flips this cycle
- sign_upd_x  in  NUM_LQ  X-sign flip mask
- sign_upd_z  in  NUM_LQ  Z-sign flip mask
- lq_clear  in  1  clear all accumulated state
- a_valid  in  1  "a" value available
- a_val  in  1  "a" value
- out_valid  out  1  final_meas valid
- out_ready  in  1  consumer accepts final_meas
- final_meas  out  1  interpreted outcome
- byproduct_acc  out  NUM_LQ*2  accumulated byproduct register
- measfb_xorz  out  2  feedback code, `FBXORZ_X / `FBXORZ_Z / `FBXORZ_INVALID
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (synchronous, rst=1 at clock edge):
  - FSM goes to IDLE.
  - lqsignX_acc, lqsignZ_acc, byproduct_acc, a_sign, a_taken, final_meas all go to 0; a_sign=0 is `MEASSIGN_PLUS.
  - out_valid=0, measfb_xorz=`FBXORZ_INVALID.
  - Reset mid-operation discards the in-flight record.
- FSM states: IDLE, EVAL, OUT.
  - IDLE: meas_ready=1. meas_valid=1 latches lpplist, byproduct, meas_sign, init_meas, byproduct_check and meas_is_a, then goes to EVAL.
  - EVAL (exactly 1 cycle), on the latched record:
    - not_commute = XOR over qubits of (lpp!=bpp & lpp!=`PP_I & bpp!=`PP_I).
    - lqsign = XOR over qubits of: X-acc for `PP_X, Z-acc for `PP_Z, X-acc^Z-acc for `PP_Y, nothing for `PP_I.
    - final_meas <= (not_commute & byproduct_check) ^ lqsign ^ meas_sign ^ init_meas.
    - byproduct_acc <= byproduct_acc ^ latched byproduct.
    - If meas_is_a: a_sign <= computed final_meas and a_taken <= 0.
    - Go to OUT.
  - OUT: out_valid=1, final_meas stable. out_ready=1 goes to IDLE, giving 3 cycles minimum from acceptance to the next meas_ready.
- meas_ready is 0 in EVAL and OUT. A record offered then is not taken.
- Sign update: when sign_upd_valid=1, in any state, lqsignX_acc ^= sign_upd_x and lqsignZ_acc ^= sign_upd_z at the clock edge. If an update coincides with EVAL, EVAL uses the pre-update accumulator values.
- Feedback is combinational from registers, evaluated every cycle:
  - If a_valid & ~a_taken: measfb_xorz = `FBXORZ_X when a_val ^ a_sign = 1, else `FBXORZ_Z. a_taken <= 1 at that edge, so at most one non-INVALID code per "a" capture.
  - Otherwise measfb_xorz = `FBXORZ_INVALID.
  - If a_valid is asserted in the same cycle EVAL captures a new a_sign, feedback uses the old a_sign/a_taken. The new capture re-arms a_taken=0.
- lq_clear=1:
  - Zeroes lqsignX_acc, lqsignZ_acc, byproduct_acc, a_sign; sets a_taken=1.
  - Has priority over sign updates and the EVAL accumulate.
  - Does not change FSM state or a pending final_meas.
- busy = (state != IDLE).

Test Plan:
- Reset, then NUM_LQ=2, lpplist=X,Z, byproduct=I,I, meas_sign=1, others 0 -> out_valid 2 cycles after accept, final_meas=1, byproduct_acc=0.
- sign_upd_x=2'b01 applied, then a record with lpplist=Y,I and meas_sign=0 -> final_meas=1. Repeat with sign_upd_z=2'b01 also applied -> final_meas=0.
- Record with lpplist=X,I, byproduct=Z,I, byproduct_check=1, meas_sign=0 -> final_meas=1 and byproduct_acc=Z,I. Same record with byproduct_check=0 -> final_meas=0 and byproduct_acc=0.
- Record with meas_is_a=1 yielding final_meas=1, then a_valid=1, a_val=0 for 3 cycles -> measfb_xorz=`FBXORZ_X for one cycle only, then INVALID. After a new capture with final_meas=0 and a_val=0 -> `FBXORZ_Z.
- Hold out_ready=0 for 5 cycles while offering meas_valid -> out_valid and final_meas stable, meas_ready=0. out_ready=1 -> back to IDLE, next record accepted.
- Assert rst during OUT with nonzero accumulators -> next cycle out_valid=0, busy=0, all accumulators 0. Assert lq_clear together with sign_upd_valid -> accumulators 0.
